id_stage_hazard: RTL and testbench

- Parametrised next-generation decode stage.
- Contains a 2^REGS x NB register file, a 3-mode immediate extender, load-use hazard detection with stall generation, and the registered ID/EX pipeline boundary with bubble/flush insertion.
- Sits between the IF/ID register and the EX stage.
- Consumes decoded control bits from the control unit. Its registered ID/EX bundle drives EX directly.

---
 rtl/id_stage_hazard_if.sv | 28 ++
 rtl/id_stage_hazard.sv | 157 +++++++++++++++
 tb/tb_id_stage_hazard.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_hazard_if.sv
// ID/EX pipeline boundary bundle driven by the decode stage into EX.
// master = decode stage (drives), slave = EX stage (consumes).
interface id_stage_hazard_if #(
  parameter int NB     = 32,
  parameter int REGS   = 5,
  parameter int CTRL_W = 8
);
  logic [NB-1:0]     o_ex_data_a;
  logic [NB-1:0]     o_ex_data_b;
  logic [NB-1:0]     o_ex_imm;
  logic [NB-1:0]     o_ex_pc;
  logic [REGS-1:0]   o_ex_rs;
  logic [REGS-1:0]   o_ex_rt;
  logic [REGS-1:0]   o_ex_reg_dest;
  logic              o_ex_mem_read;
  logic              o_ex_reg_write;
  logic [CTRL_W-1:0] o_ex_ctrl;
  logic              o_ex_valid;

  modport master (
    output o_ex_data_a, o_ex_data_b, o_ex_imm, o_ex_pc, o_ex_rs, o_ex_rt,
           o_ex_reg_dest, o_ex_mem_read, o_ex_reg_write, o_ex_ctrl, o_ex_valid
  );
  modport slave (
    input  o_ex_data_a, o_ex_data_b, o_ex_imm, o_ex_pc, o_ex_rs, o_ex_rt,
           o_ex_reg_dest, o_ex_mem_read, o_ex_reg_write, o_ex_ctrl, o_ex_valid
  );
endinterface

// File: rtl/id_stage_hazard.sv
// Decode stage: register file, immediate extender, load-use stall and ID/EX register.
// Optional macro ID_WB_BYPASS_EN adds a write-first WB bypass on the rs/rt read ports.
module id_stage_hazard #(
  parameter int NB     = 32,
  parameter int REGS   = 5,
  parameter int INBITS = 16,
  parameter int CTRL_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic [NB-1:0]     i_instruction,
  input  logic [NB-1:0]     i_pc,
  input  logic              i_uses_rs,
  input  logic              i_uses_rt,
  input  logic              i_mem_read,
  input  logic              i_reg_write,
  input  logic [REGS-1:0]   i_reg_dest,
  input  logic [1:0]        i_ext_mode,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_wb_reg_write,
  input  logic [REGS-1:0]   i_wb_reg_dir,
  input  logic [NB-1:0]     i_wb_reg_write_data,
  input  logic [REGS-1:0]   i_dbg_reg_dir,
  output logic [NB-1:0]     o_dbg_reg_data,
  output logic              o_stall,
  id_stage_hazard_if.master ex_if
);

  localparam int DEPTH = 2 ** REGS;

  logic [NB-1:0]     r_regs [DEPTH];
  logic [DEPTH-1:0]  w_we;

  logic [NB-1:0]     r_ex_data_a, r_ex_data_b, r_ex_imm, r_ex_pc;
  logic [REGS-1:0]   r_ex_rs, r_ex_rt, r_ex_reg_dest;
  logic              r_ex_mem_read, r_ex_reg_write, r_ex_valid;
  logic [CTRL_W-1:0] r_ex_ctrl;

  logic [REGS-1:0]   w_rs, w_rt;
  logic [INBITS-1:0] w_imm;
  logic [NB-1:0]     w_imm_ext;
  logic [NB-1:0]     w_rd_a, w_rd_b;
  logic              w_haz;
  logic              w_unused;

  assign w_rs  = i_instruction[INBITS+2*REGS-1 -: REGS];
  assign w_rt  = i_instruction[INBITS+REGS-1 -: REGS];
  assign w_imm = i_instruction[INBITS-1:0];
  assign w_unused = ^i_instruction[NB-1:INBITS+2*REGS];

  // Register 0 never gets a write enable, so it stays at its reset value of 0.
  assign w_we[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = i_step & i_wb_reg_write & (i_wb_reg_dir == REGS'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) r_regs[i] <= i_wb_reg_write_data;
      end
    end
  end

`ifdef ID_WB_BYPASS_EN
  // Write-first: a same-cycle WB to the register being read wins over stored data.
  always_comb begin
    w_rd_a = (w_rs == '0) ? '0 : r_regs[w_rs];
    w_rd_b = (w_rt == '0) ? '0 : r_regs[w_rt];
    if (i_wb_reg_write && (i_wb_reg_dir != '0) && (i_wb_reg_dir == w_rs)) w_rd_a = i_wb_reg_write_data;
    if (i_wb_reg_write && (i_wb_reg_dir != '0) && (i_wb_reg_dir == w_rt)) w_rd_b = i_wb_reg_write_data;
  end
`else
  always_comb begin
    w_rd_a = (w_rs == '0) ? '0 : r_regs[w_rs];
    w_rd_b = (w_rt == '0) ? '0 : r_regs[w_rt];
  end
`endif

  assign o_dbg_reg_data = (i_dbg_reg_dir == '0) ? '0 : r_regs[i_dbg_reg_dir];

  always_comb begin
    case (i_ext_mode)
      2'b01:   w_imm_ext = {{(NB-INBITS){1'b0}}, w_imm};
      2'b10:   w_imm_ext = {w_imm, {(NB-INBITS){1'b0}}};
      default: w_imm_ext = {{(NB-INBITS){w_imm[INBITS-1]}}, w_imm};
    endcase
  end

  // The bubble clears r_ex_valid, which is what limits a load-use stall to one cycle.
  assign w_haz = r_ex_valid & r_ex_mem_read & (r_ex_reg_dest != '0) &
                 ((i_uses_rs & (w_rs == r_ex_reg_dest)) |
                  (i_uses_rt & (w_rt == r_ex_reg_dest)));
  assign o_stall = w_haz & ~i_flush;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ex_data_a    <= '0;
      r_ex_data_b    <= '0;
      r_ex_imm       <= '0;
      r_ex_pc        <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_reg_dest  <= '0;
      r_ex_mem_read  <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_ctrl      <= '0;
      r_ex_valid     <= 1'b0;
    end else if (i_step) begin
      if (i_flush || w_haz) begin
        r_ex_data_a    <= '0;
        r_ex_data_b    <= '0;
        r_ex_imm       <= '0;
        r_ex_pc        <= '0;
        r_ex_rs        <= '0;
        r_ex_rt        <= '0;
        r_ex_reg_dest  <= '0;
        r_ex_mem_read  <= 1'b0;
        r_ex_reg_write <= 1'b0;
        r_ex_ctrl      <= '0;
        r_ex_valid     <= 1'b0;
      end else begin
        r_ex_data_a    <= w_rd_a;
        r_ex_data_b    <= w_rd_b;
        r_ex_imm       <= w_imm_ext;
        r_ex_pc        <= i_pc;
        r_ex_rs        <= w_rs;
        r_ex_rt        <= w_rt;
        r_ex_reg_dest  <= i_reg_dest;
        r_ex_mem_read  <= i_mem_read;
        r_ex_reg_write <= i_reg_write;
        r_ex_ctrl      <= i_ctrl;
        r_ex_valid     <= 1'b1;
      end
    end
  end

  assign ex_if.o_ex_data_a    = r_ex_data_a;
  assign ex_if.o_ex_data_b    = r_ex_data_b;
  assign ex_if.o_ex_imm       = r_ex_imm;
  assign ex_if.o_ex_pc        = r_ex_pc;
  assign ex_if.o_ex_rs        = r_ex_rs;
  assign ex_if.o_ex_rt        = r_ex_rt;
  assign ex_if.o_ex_reg_dest  = r_ex_reg_dest;
  assign ex_if.o_ex_mem_read  = r_ex_mem_read;
  assign ex_if.o_ex_reg_write = r_ex_reg_write;
  assign ex_if.o_ex_ctrl      = r_ex_ctrl;
  assign ex_if.o_ex_valid     = r_ex_valid;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard: reset, regfile, extension, load-use, flush, step, bypass.
module tb_id_stage_hazard;
  localparam int NB = 32, REGS = 5, INBITS = 16, CTRL_W = 8;

  logic              i_clk = 1'b0;
  logic              i_reset_n, i_step, i_flush;
  logic [NB-1:0]     i_instruction, i_pc;
  logic              i_uses_rs, i_uses_rt, i_mem_read, i_reg_write;
  logic [REGS-1:0]   i_reg_dest;
  logic [1:0]        i_ext_mode;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_wb_reg_write;
  logic [REGS-1:0]   i_wb_reg_dir;
  logic [NB-1:0]     i_wb_reg_write_data;
  logic [REGS-1:0]   i_dbg_reg_dir;
  logic [NB-1:0]     o_dbg_reg_data;
  logic              o_stall;

  int n_vec = 0;
  int n_err = 0;

  id_stage_hazard_if #(.NB(NB), .REGS(REGS), .CTRL_W(CTRL_W)) ex_if ();

  id_stage_hazard #(.NB(NB), .REGS(REGS), .INBITS(INBITS), .CTRL_W(CTRL_W)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_step(i_step), .i_flush(i_flush),
    .i_instruction(i_instruction), .i_pc(i_pc), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
    .i_mem_read(i_mem_read), .i_reg_write(i_reg_write), .i_reg_dest(i_reg_dest),
    .i_ext_mode(i_ext_mode), .i_ctrl(i_ctrl), .i_wb_reg_write(i_wb_reg_write),
    .i_wb_reg_dir(i_wb_reg_dir), .i_wb_reg_write_data(i_wb_reg_write_data),
    .i_dbg_reg_dir(i_dbg_reg_dir), .o_dbg_reg_data(o_dbg_reg_data), .o_stall(o_stall),
    .ex_if(ex_if)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_flush = 0; i_instruction = mk(5'd0, 5'd0, 16'h0); i_pc = 0;
    i_uses_rs = 0; i_uses_rt = 0; i_mem_read = 0; i_reg_write = 0; i_reg_dest = 0;
    i_ext_mode = 0; i_ctrl = 0; i_wb_reg_write = 0; i_wb_reg_dir = 0;
    i_wb_reg_write_data = 0; i_dbg_reg_dir = 0;
  endtask

  task automatic load_in_ex(input logic [4:0] dest);
    idle_inputs();
    i_instruction = mk(5'd1, 5'd2, 16'h0004);
    i_mem_read = 1; i_reg_write = 1; i_reg_dest = dest;
    tick();
  endtask

  task automatic test_reset();
    i_reset_n = 0; i_step = 1; idle_inputs();
    #2;
    n_vec++; if (ex_if.o_ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ex_if.o_ex_valid); end
    n_vec++; if (ex_if.o_ex_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", ex_if.o_ex_pc); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", o_stall); end
    @(negedge i_clk); i_reset_n = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_regfile();
    idle_inputs();
    i_wb_reg_write = 1; i_wb_reg_dir = 5; i_wb_reg_write_data = 32'hDEADBEEF;
    tick();
    i_wb_reg_dir = 0; i_wb_reg_write_data = 32'h1234;
    i_dbg_reg_dir = 5; #1;
    n_vec++; if (o_dbg_reg_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL dbg_r5 got %h exp deadbeef", o_dbg_reg_data); end
    tick();
    i_wb_reg_write = 0; i_dbg_reg_dir = 0; #1;
    n_vec++; if (o_dbg_reg_data !== 32'h0) begin n_err++; $display("FAIL dbg_r0 got %h exp 0", o_dbg_reg_data); end
    i_instruction = mk(5'd5, 5'd0, 16'h0); i_pc = 32'h40; i_ctrl = 8'h3C;
    tick();
    n_vec++; if (ex_if.o_ex_data_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL rs_read got %h exp deadbeef", ex_if.o_ex_data_a); end
    n_vec++; if (ex_if.o_ex_data_b !== 32'h0) begin n_err++; $display("FAIL rt_r0 got %h exp 0", ex_if.o_ex_data_b); end
    n_vec++; if (ex_if.o_ex_pc !== 32'h40 || ex_if.o_ex_ctrl !== 8'h3C || ex_if.o_ex_valid !== 1'b1) begin
      n_err++; $display("FAIL latch pc=%h ctrl=%h v=%b exp 40 3c 1", ex_if.o_ex_pc, ex_if.o_ex_ctrl, ex_if.o_ex_valid); end
    $display("test_regfile done");
  endtask

  task automatic test_extension();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'hFFFF8001; exp_v[1] = 32'h00008001; exp_v[2] = 32'h80010000; exp_v[3] = 32'hFFFF8001;
    for (int m = 0; m < 4; m++) begin
      idle_inputs();
      i_instruction = mk(5'd0, 5'd0, 16'h8001); i_ext_mode = 2'(m);
      tick();
      n_vec++; if (ex_if.o_ex_imm !== exp_v[m]) begin n_err++; $display("FAIL ext_mode%0d got %h exp %h", m, ex_if.o_ex_imm, exp_v[m]); end
    end
    $display("test_extension done");
  endtask

  task automatic test_load_use();
    load_in_ex(5'd3);
    idle_inputs();
    i_instruction = mk(5'd3, 5'd4, 16'h0); i_uses_rs = 1; i_reg_write = 1; i_reg_dest = 6; i_ctrl = 8'h5A; i_pc = 32'h80;
    #1;
    n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", o_stall); end
    tick();
    n_vec++; if (ex_if.o_ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %b exp 0", ex_if.o_ex_valid); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_len got %b exp 0", o_stall); end
    tick();
    n_vec++; if (ex_if.o_ex_valid !== 1'b1 || ex_if.o_ex_reg_dest !== 5'd6 || ex_if.o_ex_ctrl !== 8'h5A || ex_if.o_ex_rs !== 5'd3) begin
      n_err++; $display("FAIL lu_issue v=%b dest=%0d ctrl=%h rs=%0d exp 1 6 5a 3", ex_if.o_ex_valid, ex_if.o_ex_reg_dest, ex_if.o_ex_ctrl, ex_if.o_ex_rs); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_after got %b exp 0", o_stall); end
    load_in_ex(5'd0);
    idle_inputs();
    i_instruction = mk(5'd0, 5'd0, 16'h0); i_uses_rs = 1; #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_dest0 got %b exp 0", o_stall); end
    load_in_ex(5'd7);
    idle_inputs();
    i_instruction = mk(5'd1, 5'd7, 16'h0); i_uses_rt = 0; #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_rt_unused got %b exp 0", o_stall); end
    i_uses_rt = 1; #1;
    n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_rt got %b exp 1", o_stall); end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_flush();
    load_in_ex(5'd3);
    idle_inputs();
    i_instruction = mk(5'd3, 5'd0, 16'h0); i_uses_rs = 1; i_flush = 1; i_reg_write = 1; i_ctrl = 8'hFF; #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b exp 0", o_stall); end
    tick();
    n_vec++; if (ex_if.o_ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_bubble got %b exp 0", ex_if.o_ex_valid); end
    idle_inputs();
    i_instruction = mk(5'd1, 5'd2, 16'h0); i_flush = 1; i_reg_write = 1; i_mem_read = 1; i_ctrl = 8'hFF; i_reg_dest = 9;
    tick();
    n_vec++; if (ex_if.o_ex_reg_write !== 1'b0 || ex_if.o_ex_ctrl !== 8'h00 || ex_if.o_ex_mem_read !== 1'b0) begin
      n_err++; $display("FAIL flush_only rw=%b ctrl=%h mr=%b exp 0 00 0", ex_if.o_ex_reg_write, ex_if.o_ex_ctrl, ex_if.o_ex_mem_read); end
    $display("test_flush done");
  endtask

  task automatic test_step();
    idle_inputs();
    i_instruction = mk(5'd1, 5'd2, 16'h0); i_pc = 32'h100; i_reg_write = 1; i_reg_dest = 8;
    tick();
    i_step = 0; i_pc = 32'h200; i_reg_dest = 10;
    i_wb_reg_write = 1; i_wb_reg_dir = 7; i_wb_reg_write_data = 32'h55; i_dbg_reg_dir = 7;
    repeat (3) tick();
    n_vec++; if (o_dbg_reg_data !== 32'h0) begin n_err++; $display("FAIL step_rf got %h exp 0", o_dbg_reg_data); end
    n_vec++; if (ex_if.o_ex_pc !== 32'h100 || ex_if.o_ex_reg_dest !== 5'd8) begin
      n_err++; $display("FAIL step_idex pc=%h dest=%0d exp 100 8", ex_if.o_ex_pc, ex_if.o_ex_reg_dest); end
    i_step = 1;
    tick();
    n_vec++; if (o_dbg_reg_data !== 32'h55) begin n_err++; $display("FAIL step_rf_go got %h exp 55", o_dbg_reg_data); end
    n_vec++; if (ex_if.o_ex_pc !== 32'h200 || ex_if.o_ex_reg_dest !== 5'd10) begin
      n_err++; $display("FAIL step_idex_go pc=%h dest=%0d exp 200 10", ex_if.o_ex_pc, ex_if.o_ex_reg_dest); end
    $display("test_step done");
  endtask

  task automatic test_bypass();
    logic [31:0] exp_a;
`ifdef ID_WB_BYPASS_EN
    exp_a = 32'hA5A5A5A5;
`else
    exp_a = 32'h11111111;
`endif
    idle_inputs();
    i_wb_reg_write = 1; i_wb_reg_dir = 9; i_wb_reg_write_data = 32'h11111111;
    tick();
    i_wb_reg_write_data = 32'hA5A5A5A5; i_instruction = mk(5'd9, 5'd9, 16'h0); i_uses_rs = 1; i_uses_rt = 1;
    i_dbg_reg_dir = 9; #1;
    n_vec++; if (o_dbg_reg_data !== 32'h11111111) begin n_err++; $display("FAIL dbg_nobypass got %h exp 11111111", o_dbg_reg_data); end
    tick();
    n_vec++; if (ex_if.o_ex_data_a !== exp_a) begin n_err++; $display("FAIL bypass_a got %h exp %h", ex_if.o_ex_data_a, exp_a); end
    n_vec++; if (ex_if.o_ex_data_b !== exp_a) begin n_err++; $display("FAIL bypass_b got %h exp %h", ex_if.o_ex_data_b, exp_a); end
    $display("test_bypass done");
  endtask

  task automatic test_reset_mid_stall();
    load_in_ex(5'd3);
    idle_inputs();
    i_instruction = mk(5'd3, 5'd0, 16'h0); i_uses_rs = 1; i_dbg_reg_dir = 5; #1;
    n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall got %b exp 1", o_stall); end
    #1 i_reset_n = 0; #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", o_stall); end
    n_vec++; if (ex_if.o_ex_valid !== 1'b0 || ex_if.o_ex_mem_read !== 1'b0 || ex_if.o_ex_reg_dest !== 5'd0) begin
      n_err++; $display("FAIL rst_ex v=%b mr=%b dest=%0d exp 0 0 0", ex_if.o_ex_valid, ex_if.o_ex_mem_read, ex_if.o_ex_reg_dest); end
    n_vec++; if (o_dbg_reg_data !== 32'h0) begin n_err++; $display("FAIL rst_rf got %h exp 0", o_dbg_reg_data); end
    @(negedge i_clk); i_reset_n = 1;
    tick();
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_extension();
    test_load_use();
    test_flush();
    test_step();
    test_bypass();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
